// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multicycle control FSM: IF/ID/EX/MEM/WB sequencing with a memory-ack timeout.
// Define LEGV8_MC_ILLEGAL_TRAP_EN to build the sticky TRAP state for illegal opcodes.
module legv8_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [10:0] opcode,
    input  logic        mem_ack,
    output logic        reg2loc,
    output logic        alusrc,
    output logic        mem2reg,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        branch,
    output logic        uncond_branch,
    output logic        pcwrite,
    output logic        irwrite,
    output logic [3:0]  aluop,
    output logic [2:0]  signop,
    output logic        mem_err,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
`ifdef LEGV8_MC_ILLEGAL_TRAP_EN
        S_TRAP = 3'd5,
`endif
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_ILL, C_ALU, C_B, C_CBZ, C_LD, C_ST
    } iclass_t;

    state_t           state_q, state_d;
    logic [10:0]      ir_q;
    logic [CNT_W-1:0] cnt_q;
    iclass_t          cls;
    logic             d_reg2loc, d_alusrc, d_mem2reg;
    logic [3:0]       d_aluop;
    logic [2:0]       d_signop;
    logic             mem_last;

    assign state    = state_q;
    assign mem_last = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IF && !stall)
                ir_q <= opcode;
            if (state_q == S_EX)
                cnt_q <= '0;
            else if (state_q == S_MEM && !mem_ack && !mem_last)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        cls       = C_ILL;
        d_reg2loc = 1'b0;
        d_alusrc  = 1'b0;
        d_mem2reg = 1'b0;
        d_aluop   = 4'b0000;
        d_signop  = 3'b000;
        unique casez (ir_q)
            11'b10001010000: begin
                cls = C_ALU;
            end
            11'b10101010000: begin
                cls = C_ALU; d_aluop = 4'b0001;
            end
            11'b10001011000: begin
                cls = C_ALU; d_aluop = 4'b0010;
            end
            11'b11001011000: begin
                cls = C_ALU; d_aluop = 4'b0110;
            end
            11'b1001000100?: begin
                cls = C_ALU; d_alusrc = 1'b1; d_aluop = 4'b0010;
            end
            11'b1101000100?: begin
                cls = C_ALU; d_alusrc = 1'b1; d_aluop = 4'b0110;
            end
            11'b110100101??: begin
                cls = C_ALU; d_alusrc = 1'b1;
                d_aluop = 4'b1000; d_signop = 3'b100;
            end
            11'b000101?????: begin
                cls = C_B; d_signop = 3'b010;
            end
            11'b10110100???: begin
                cls = C_CBZ; d_reg2loc = 1'b1;
                d_aluop = 4'b0111; d_signop = 3'b011;
            end
            11'b11111000010: begin
                cls = C_LD; d_alusrc = 1'b1; d_mem2reg = 1'b1;
                d_aluop = 4'b0010; d_signop = 3'b001;
            end
            11'b11111000000: begin
                cls = C_ST; d_reg2loc = 1'b1; d_alusrc = 1'b1;
                d_aluop = 4'b0010; d_signop = 3'b001;
            end
            default: cls = C_ILL;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        irwrite       = 1'b0;
        regwrite      = 1'b0;
        memread       = 1'b0;
        memwrite      = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        pcwrite       = 1'b0;
        mem_err       = 1'b0;
        reg2loc       = 1'b0;
        alusrc        = 1'b0;
        mem2reg       = 1'b0;
        aluop         = 4'b0000;
        signop        = 3'b000;
        case (state_q)
            S_IF: begin
                if (!stall) begin
                    irwrite = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (cls == C_ILL) begin
`ifdef LEGV8_MC_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    pcwrite = 1'b1;
                    state_d = S_IF;
`endif
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                case (cls)
                    C_CBZ: begin
                        branch  = 1'b1;
                        pcwrite = 1'b1;
                        state_d = S_IF;
                    end
                    C_B: begin
                        uncond_branch = 1'b1;
                        pcwrite       = 1'b1;
                        state_d       = S_IF;
                    end
                    C_LD, C_ST: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                memread  = (cls == C_LD);
                memwrite = (cls == C_ST);
                // ack takes priority over a timeout landing in the same cycle
                if (mem_ack) begin
                    if (cls == C_LD) begin
                        state_d = S_WB;
                    end else begin
                        pcwrite = 1'b1;
                        state_d = S_IF;
                    end
                end else if (mem_last) begin
                    mem_err = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_IF;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                pcwrite  = 1'b1;
                state_d  = S_IF;
            end
`ifdef LEGV8_MC_ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_IF;
        endcase
        if (state_q == S_ID || state_q == S_EX ||
            state_q == S_MEM || state_q == S_WB) begin
            reg2loc = d_reg2loc;
            alusrc  = d_alusrc;
            mem2reg = d_mem2reg;
            aluop   = d_aluop;
            signop  = d_signop;
        end
        // a reset mid-instruction must not leave a partial write behind
        if (reset) begin
            regwrite      = 1'b0;
            memread       = 1'b0;
            memwrite      = 1'b0;
            branch        = 1'b0;
            uncond_branch = 1'b0;
            pcwrite       = 1'b0;
            mem_err       = 1'b0;
        end
    end

endmodule
